// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer.
// Aligns, drives the data bus, and returns extended load data.
module mem_access_unit #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iReq,
  output logic              oReady,
  input  logic              iWrite,
  input  logic [1:0]        iSize,
  input  logic              iUnsigned,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iWData,
  output logic              oValid,
  output logic [31:0]       oRData,
  output logic              oMisalign,
  output logic              oReadEnable,
  output logic              oWriteEnable,
  output logic [3:0]        oByteEnable,
  output logic [ADDR_W-1:0] oAddress,
  output logic [31:0]       oWriteData,
  input  logic [31:0]       iReadData
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lo_q;
  logic [3:0]  cnt;

  logic        mis;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  // Request decode: alignment, lane enables, replicated store data.
  always_comb begin
    mis = 1'b0;
    be  = 4'b0000;
    wd  = iWData;
    unique case (iSize)
      2'b00: begin
        be = 4'b0001 << iAddr[1:0];
        wd = {4{iWData[7:0]}};
      end
      2'b01: begin
        mis = iAddr[0];
        be  = iAddr[1] ? 4'b1100 : 4'b0011;
        wd  = {2{iWData[15:0]}};
      end
      2'b10: begin
        mis = |iAddr[1:0];
        be  = 4'b1111;
      end
      default: mis = 1'b1;
    endcase
  end

  // Load extraction: lane shift then sign/zero extension.
  always_comb begin
    byte_sel = 8'(iReadData >> {lo_q, 3'b000});
    half_sel = 16'(iReadData >> {lo_q[1], 4'b0000});
    ext      = iReadData;
    unique case (size_q)
      2'b00:   ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   ext = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: ext = iReadData;
    endcase
  end

  // Sequencer with all outputs registered.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state        <= IDLE;
      oReady       <= 1'b1;
      oValid       <= 1'b0;
      oMisalign    <= 1'b0;
      oRData       <= '0;
      oReadEnable  <= 1'b0;
      oWriteEnable <= 1'b0;
      oByteEnable  <= '0;
      oAddress     <= '0;
      oWriteData   <= '0;
      wr_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      lo_q         <= '0;
      cnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iReq) begin
            wr_q   <= iWrite;
            size_q <= iSize;
            uns_q  <= iUnsigned;
            lo_q   <= iAddr[1:0];
            oReady <= 1'b0;
            if (mis) begin
              state     <= RESP;
              oValid    <= 1'b1;
              oMisalign <= 1'b1;
            end else begin
              state        <= ACCESS;
              oAddress     <= {iAddr[ADDR_W-1:2], 2'b00};
              oByteEnable  <= be;
              oWriteData   <= wd;
              oWriteEnable <= iWrite;
              oReadEnable  <= ~iWrite;
            end
          end
        end
        ACCESS: begin
          if (wr_q) begin
            state        <= RESP;
            oValid       <= 1'b1;
            oWriteEnable <= 1'b0;
            oByteEnable  <= '0;
            oAddress     <= '0;
            oWriteData   <= '0;
          end else begin
            state <= WAIT;
            cnt   <= WAIT_LD;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= RESP;
            oValid      <= 1'b1;
            oRData      <= ext;
            oReadEnable <= 1'b0;
            oByteEnable <= '0;
            oAddress    <= '0;
            oWriteData  <= '0;
          end
        end
        RESP: begin
          state     <= IDLE;
          oValid    <= 1'b0;
          oMisalign <= 1'b0;
          oReady    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized check of two instances
// (WAIT_CYCLES 1 and 3) against a behavioural model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req;
  logic        wr;
  logic [1:0]  sz;
  logic        un;
  logic [31:0] ad;
  logic [31:0] wd;
  logic [31:0] rd;

  logic [1:0]       rdy, vld, mis, re, we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr, wdat, rdat;

  int n_checks = 0;
  int n_errors = 0;
  int cur_dut  = 0;
  logic [31:0] exp_rd [2];

  mem_access_unit #(.WAIT_CYCLES(1), .ADDR_W(32)) u_dut1 (
    .iCLK(clk), .iRST_n(rst_n), .iReq(req), .oReady(rdy[0]),
    .iWrite(wr), .iSize(sz), .iUnsigned(un), .iAddr(ad),
    .iWData(wd), .oValid(vld[0]), .oRData(rdat[0]),
    .oMisalign(mis[0]), .oReadEnable(re[0]),
    .oWriteEnable(we[0]), .oByteEnable(be[0]),
    .oAddress(addr[0]), .oWriteData(wdat[0]), .iReadData(rd)
  );

  mem_access_unit #(.WAIT_CYCLES(3), .ADDR_W(32)) u_dut3 (
    .iCLK(clk), .iRST_n(rst_n), .iReq(req), .oReady(rdy[1]),
    .iWrite(wr), .iSize(sz), .iUnsigned(un), .iAddr(ad),
    .iWData(wd), .oValid(vld[1]), .oRData(rdat[1]),
    .oMisalign(mis[1]), .oReadEnable(re[1]),
    .oWriteEnable(we[1]), .oByteEnable(be[1]),
    .oAddress(addr[1]), .oWriteData(wdat[1]), .iReadData(rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got 0x%08h, want 0x%08h",
               tag, cur_dut, obs, exp);
    end
  endtask

  function automatic int wc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic m_mis(input logic [1:0] s, input logic [31:0] a);
    int nb;
    if (s == 2'd3) return 1'b1;
    nb = 1 << s;
    return (int'(a[1:0]) % nb) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] s, input int lo);
    int v;
    if (s == 2'd0)      v = 1 << lo;
    else if (s == 2'd1) v = 3 << lo;
    else                v = 15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] s,
                                       input logic [31:0] d);
    logic [31:0] b, h;
    b = {24'd0, d[7:0]};
    h = {16'd0, d[15:0]};
    if (s == 2'd0)      return b * 32'h01010101;
    else if (s == 2'd1) return h * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] s, input logic u,
                                       input int lo, input logic [31:0] r);
    logic [31:0] v;
    if (s == 2'd0) begin
      v = (r >> (8 * lo)) & 32'hFF;
      if (!u && v >= 32'd128) v = v - 32'd256;
    end else if (s == 2'd1) begin
      v = (r >> (16 * (lo / 2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  task automatic do_req(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] r);
    int vk[2], vc[2], wec[2], rec[2], fen[2], bad[2];
    logic mk[2];
    logic m;
    int lo;
    logic [3:0] ebe;
    logic [31:0] ewd;
    m   = m_mis(s, a);
    lo  = int'(a[1:0]);
    ebe = m_be(s, lo);
    ewd = m_wd(s, d);
    for (int i = 0; i < 2; i++) begin
      vk[i] = 0; vc[i] = 0; wec[i] = 0; rec[i] = 0;
      fen[i] = 0; bad[i] = 0; mk[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cur_dut = i;
      chk("ready_pre", 32'(rdy[i]), 32'd1);
    end
    req = 1'b1; wr = w; sz = s; un = u; ad = a; wd = d; rd = r;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (vld[i]) begin
          vc[i]++;
          if (vk[i] == 0) vk[i] = k;
          mk[i] = mis[i];
        end
        if (mis[i] && !vld[i]) bad[i]++;
        if (we[i]) wec[i]++;
        if (re[i]) rec[i]++;
        if (we[i] || re[i]) begin
          if (fen[i] == 0) fen[i] = k;
          if (addr[i] != {a[31:2], 2'b00}) bad[i]++;
          if (be[i] != ebe) bad[i]++;
          if (we[i] && wdat[i] != ewd) bad[i]++;
        end
      end
      if (k == 1) req = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      cur_dut = i;
      if (!m && !w) exp_rd[i] = m_ld(s, u, lo, r);
      chk("valid_cnt", 32'(vc[i]), 32'd1);
      chk("valid_lat", 32'(vk[i]),
          32'(m ? 1 : (w ? 2 : 2 + wc(i))));
      chk("misalign", 32'(mk[i]), 32'(m));
      chk("we_cycles", 32'(wec[i]), 32'((!m && w) ? 1 : 0));
      chk("re_cycles", 32'(rec[i]), 32'((!m && !w) ? wc(i) + 1 : 0));
      chk("en_start", 32'(fen[i]), 32'(m ? 0 : 1));
      chk("bus", 32'(bad[i]), 32'd0);
      chk("rdata", rdat[i], exp_rd[i]);
      chk("ready_post", 32'(rdy[i]), 32'd1);
    end
  endtask

  task automatic rst_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      cur_dut = i;
      chk({tag, "_ready"}, 32'(rdy[i]), 32'd1);
      chk({tag, "_valid"}, 32'({vld[i], mis[i]}), 32'd0);
      chk({tag, "_rdata"}, rdat[i], 32'd0);
      chk({tag, "_bus"}, addr[i] | wdat[i] | 32'(be[i]) |
          32'({re[i], we[i]}), 32'd0);
    end
  endtask

  initial begin
    int nv[2], nr[2];
    rst_n = 1'b0;
    req = 1'b0; wr = 1'b0; sz = 2'd0; un = 1'b0;
    ad = '0; wd = '0; rd = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (3) @(negedge clk);
    rst_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 2'd2, 1'b0, 32'h10010004, 32'hDEADBEEF, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h10010003, 32'h0000005A, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h10010002, 32'h00001234, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 32'h10010001, 32'h0, 32'h80FF7F01);
    do_req(1'b0, 2'd0, 1'b0, 32'h10010002, 32'h0, 32'h80FF7F01);
    do_req(1'b0, 2'd0, 1'b1, 32'h10010003, 32'h0, 32'h80FF7F01);
    do_req(1'b0, 2'd1, 1'b0, 32'h10010002, 32'h0, 32'h80FF7F01);
    do_req(1'b0, 2'd1, 1'b1, 32'h10010000, 32'h0, 32'h80FF7F01);
    do_req(1'b0, 2'd2, 1'b0, 32'h10010002, 32'h0, 32'h12345678);
    do_req(1'b1, 2'd1, 1'b0, 32'h10010001, 32'hFFFF, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10010000, 32'h0, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10010008, 32'h0, 32'hCAFEF00D);

    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
    end

    // iReq held high: one access per ready window.
    for (int i = 0; i < 2; i++) begin
      nv[i] = 0;
      nr[i] = 0;
    end
    @(negedge clk);
    req = 1'b1; wr = 1'b0; sz = 2'd2; un = 1'b0;
    ad = 32'h10010020; rd = 32'h0BADF00D;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (vld[i]) nv[i]++;
        if (re[i]) nr[i]++;
      end
      if (k == 23) req = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      cur_dut = i;
      exp_rd[i] = 32'h0BADF00D;
      chk("hold_valids", 32'(nv[i]), 32'((24 + wc(i) + 2) / (wc(i) + 3)));
      chk("hold_re_cyc", 32'(nr[i]),
          32'(((24 + wc(i) + 2) / (wc(i) + 3)) * (wc(i) + 1)));
      chk("hold_rdata", rdat[i], exp_rd[i]);
    end

    // Reset while both instances are in WAIT.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; sz = 2'd2; ad = 32'h10010008;
    rd = 32'h55AA55AA;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_state("midrst");
    for (int i = 0; i < 2; i++) exp_rd[i] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        cur_dut = i;
        chk("midrst_novalid", 32'(vld[i]), 32'd0);
      end
    end
    rst_n = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h10010008, 32'h0, 32'h600DCAFE);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequencer between the pipeline MEM stage and the data memory interface.
- Accepts one load/store request at a time over a req/ready handshake.
- Checks alignment, then drives address, byte enables, lane-replicated write data and read/write enables for a fixed number of cycles.
- Captures read data after a programmable wait, then returns it shifted and sign/zero-extended with a one-cycle valid pulse.

Parameters:
WAIT_CYCLES, 1, extra cycles address/enables are held before load data is captured (1..15)
ADDR_W, 32, address width

Ports:
iCLK  input  1  system clock, all state on rising edge
iRST_n  input  1  asynchronous active-low reset
iReq  input  1  core request strobe
oReady  output  1  unit idle, request accepted when iReq && oReady
iWrite  input  1  1=store, 0=load
iSize  input  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
iUnsigned  input  1  loads: 1=zero-extend, 0=sign-extend
iAddr  input  ADDR_W  byte address
iWData  input  32  store data, right-justified
oValid  output  1  one-cycle completion pulse
oRData  output  32  aligned/extended load result, held until next accept
oMisalign  output  1  with oValid: request rejected, no memory access
oReadEnable  output  1  to memory interface
oWriteEnable  output  1  to memory interface
oByteEnable  output  4  to memory interface
oAddress  output  ADDR_W  to memory interface, word-aligned (bits[1:0]=0)
oWriteData  output  32  to memory interface, lane-replicated
iReadData  input  32  from memory interface

Behaviour:
- Reset (async, iRST_n=0): state IDLE, oReady=1, oValid=0, oMisalign=0, oRData=0, all memory outputs 0, wait counter 0. Reset asserted mid-access aborts immediately; a store in flight may be lost. No response is produced.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - oReady=1.
  - On accept, register iWrite, iSize, iUnsigned, iAddr[1:0] and iWData.
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=11. Misaligned -> RESP with oMisalign=1; memory enables stay 0.
  - Otherwise -> ACCESS.
- ACCESS (1 cycle):
  - oAddress={addr[ADDR_W-1:2],2'b00}.
  - Byte enables: byte -> 0001<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1); word -> 1111.
  - Write data: byte -> {4{d[7:0]}}; half -> {2{d[15:0]}}; word -> d.
  - Store: oWriteEnable=1, oReadEnable=0, then -> RESP.
  - Load: oReadEnable=1, counter loaded with WAIT_CYCLES, then -> WAIT.
- WAIT:
  - oReadEnable, oAddress and oByteEnable are held; the counter decrements.
  - When counter==1, on that edge capture iReadData into oRData, then -> RESP.
  - Extraction: shift right by 8*addr[1:0] (byte) or 16*addr[1] (half); extend bit 7/15 unless iUnsigned. Word is passed through.
- RESP (1 cycle):
  - oValid=1, oReady=0, memory enables 0. oMisalign is valid only here.
  - Then -> IDLE.
- Latency, accept at edge T:
  - store: enable high in cycle T+1, oValid in T+2.
  - load: enable high T+1..T+1+WAIT_CYCLES, oValid in T+2+WAIT_CYCLES.
  - misaligned: oValid in T+1.
- oReady=0 in ACCESS/WAIT/RESP; iReq ignored there. No back-to-back accept: minimum request spacing is 3 cycles for stores, 2 for misaligned.
- oRData is unchanged by stores and misaligned responses.
- All memory-side outputs come directly from registers (no combinational path from core inputs).

Test Plan:
- Store word 0xDEADBEEF @0x10010004 -> T+1: oWriteEnable=1, oByteEnable=1111, oAddress=0x10010004, oWriteData=0xDEADBEEF; T+2: oValid=1, oMisalign=0.
- Store byte 0x5A @0x10010003 -> oByteEnable=1000, oWriteData=0x5A5A5A5A; store half 0x1234 @0x10010002 -> oByteEnable=1100, oWriteData=0x12341234.
- Load with iReadData=0x80FF7F01, WAIT_CYCLES=1:
  - lb @+1 -> oRData=0x0000007F.
  - lb @+2 -> 0xFFFFFFFF.
  - lbu @+3 -> 0x00000080.
  - lh @+2 -> 0xFFFF80FF.
  - Each oValid arrives 3 cycles after accept.
- Misaligned: lw @0x10010002, sh @0x10010001, size=11 -> oValid+oMisalign at T+1, oReadEnable/oWriteEnable never asserted, oRData unchanged.
- WAIT_CYCLES=3 load -> oReadEnable high exactly 4 cycles, address stable throughout, oValid at T+5; iReq held high during busy -> exactly one access per oReady cycle.
- Drop iRST_n during WAIT -> all outputs 0 asynchronously, no oValid; after release, a fresh lw completes normally.
